// File: rtl/imem_prog.sv
// Run-time loadable instruction memory: host loads words over a valid/ready port, core fetches with one-cycle latency.
// Optional ROM_INIT_EN compiles in a built-in program table served from reset until the first accepted write.
module imem_prog #(
    parameter int ADDR_W = 6,
    parameter int OP_W   = 16,
    parameter int DEPTH  = 42
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    output logic [OP_W-1:0]   op,
    output logic              op_valid,
    output logic              fetch_fault,
    output logic              stall,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [OP_W-1:0]   ld_data,
    input  logic              ld_last,
    output logic              ld_err,
    output logic [ADDR_W:0]   loaded_cnt,
    output logic [1:0]        fsm_state
);

    // Handshake: a write transfers on every rising edge where ld_valid && ld_ready;
    // ld_ready is low only in the cycle following reset, fetch_req has no backpressure.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

`ifdef ROM_INIT_EN
    localparam state_t RESET_STATE = RUN;
`else
    localparam state_t RESET_STATE = EMPTY;
`endif

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    state_t            state;
    state_t            state_nx;
    logic              wr_acc;
    logic              fetch_acc;
    logic              wr_in_range;
    logic              pc_in_range;
    logic [ADDR_W:0]   cnt_base;
    logic              err_base;
    logic [OP_W-1:0]   rd_word;
    logic [OP_W-1:0]   mem [DEPTH];

`ifdef ROM_INIT_EN
    logic rom_sel;

    function automatic logic [OP_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return OP_W'(32'hA000 + 32'(a) * 32'd3);
    endfunction
`endif

    assign stall     = (state != RUN);
    assign fsm_state = state;

    always_comb begin
        state_nx    = state;
        wr_acc      = ld_valid && ld_ready;
        fetch_acc   = fetch_req && (state == RUN) && !wr_acc;
        wr_in_range = {1'b0, ld_addr} < DEPTH_W;
        pc_in_range = {1'b0, pc} < DEPTH_W;
        // A write arriving outside LOAD starts a fresh image, so status restarts from zero.
        cnt_base    = (state == LOAD) ? loaded_cnt : '0;
        err_base    = (state == LOAD) ? ld_err : 1'b0;
        if (wr_acc) begin
            state_nx = ld_last ? RUN : LOAD;
        end
`ifdef ROM_INIT_EN
        rd_word = rom_sel ? rom_word(pc) : mem[pc];
`else
        rd_word = mem[pc];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RESET_STATE;
            ld_ready    <= 1'b0;
            ld_err      <= 1'b0;
            loaded_cnt  <= '0;
            op          <= '0;
            op_valid    <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_nx;
            ld_ready    <= 1'b1;
            op_valid    <= fetch_acc;
            fetch_fault <= fetch_acc && !pc_in_range;
            if (fetch_acc) begin
                op <= pc_in_range ? rd_word : '0;
            end
            if (wr_acc) begin
                if (wr_in_range) begin
                    ld_err     <= err_base;
                    loaded_cnt <= (cnt_base == DEPTH_W) ? cnt_base : cnt_base + 1'b1;
                end else begin
                    ld_err     <= 1'b1;
                    loaded_cnt <= cnt_base;
                end
            end
        end
    end

`ifdef ROM_INIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_sel <= 1'b1;
        end else if (wr_acc) begin
            rom_sel <= 1'b0;
        end
    end
`endif

    // Memory is deliberately not reset so a partial image survives rst.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc && wr_in_range) begin
            mem[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_prog.sv
// Bench for imem_prog: directed load/fetch scenarios then random traffic, all checked against a behavioural model.
module tb_imem_prog;

    localparam int ADDR_W = 6;
    localparam int OP_W   = 16;
    localparam int DEPTH  = 42;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_req;
    logic [ADDR_W-1:0] pc;
    logic [OP_W-1:0]   op;
    logic              op_valid;
    logic              fetch_fault;
    logic              stall;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [OP_W-1:0]   ld_data;
    logic              ld_last;
    logic              ld_err;
    logic [ADDR_W:0]   loaded_cnt;
    logic [1:0]        fsm_state;

    imem_prog #(.ADDR_W(ADDR_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .pc         (pc),
        .op         (op),
        .op_valid   (op_valid),
        .fetch_fault(fetch_fault),
        .stall      (stall),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_err     (ld_err),
        .loaded_cnt (loaded_cnt),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a word store with per-address "written" flags and a three-mode status.
    typedef enum int {M_EMPTY, M_LOAD, M_RUN} mode_t;
    mode_t           m_mode;
    bit              m_ready;
    int              m_cnt;
    bit              m_err;
    logic [OP_W-1:0] m_mem [64];
    bit              m_known [64];
    logic [OP_W-1:0] m_op;
    bit              m_op_known;
    bit              m_opv;
    bit              m_ff;
    bit              m_rom;

    function automatic logic [OP_W-1:0] rom_ref(input int a);
        return OP_W'(40960 + 3 * a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit f, input int p, input bit v,
                              input int a, input logic [OP_W-1:0] d, input bit l);
        bit wr;
        bit fe;
        if (r) begin
`ifdef ROM_INIT_EN
            m_mode = M_RUN;
`else
            m_mode = M_EMPTY;
`endif
            m_ready = 0; m_cnt = 0; m_err = 0;
            m_op = '0; m_op_known = 1; m_opv = 0; m_ff = 0; m_rom = 1;
            return;
        end
        wr = v && m_ready;
        fe = f && (m_mode == M_RUN) && !wr;
        m_opv = fe;
        m_ff  = fe && (p >= DEPTH);
        if (fe) begin
            if (p >= DEPTH) begin
                m_op = '0; m_op_known = 1;
            end else if (m_rom) begin
                m_op = rom_ref(p); m_op_known = 1;
            end else begin
                m_op = m_mem[p]; m_op_known = m_known[p];
            end
        end
        if (wr) begin
            if (m_mode != M_LOAD) begin
                m_cnt = 0; m_err = 0;
            end
            if (a < DEPTH) begin
                m_mem[a] = d; m_known[a] = 1;
                if (m_cnt < DEPTH) m_cnt++;
            end else begin
                m_err = 1;
            end
            m_mode = l ? M_RUN : M_LOAD;
            m_rom  = 0;
        end
        m_ready = 1;
    endtask

    task automatic check_outputs();
        check("stall", 32'(stall), 32'(m_mode != M_RUN));
        check("ld_ready", 32'(ld_ready), 32'(m_ready));
        check("op_valid", 32'(op_valid), 32'(m_opv));
        check("fetch_fault", 32'(fetch_fault), 32'(m_ff));
        check("ld_err", 32'(ld_err), 32'(m_err));
        check("loaded_cnt", 32'(loaded_cnt), 32'(m_cnt));
        if (m_op_known) check("op", 32'(op), 32'(m_op));
    endtask

    task automatic step(input bit r, input bit f, input int p, input bit v,
                        input int a, input logic [OP_W-1:0] d, input bit l);
        rst = r; fetch_req = f; pc = ADDR_W'(p);
        ld_valid = v; ld_addr = ADDR_W'(a); ld_data = d; ld_last = l;
        @(posedge clk);
        model_edge(r, f, p, v, a, d, l);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_known[i] = 0;
        rst = 1; fetch_req = 0; pc = '0; ld_valid = 0; ld_addr = '0; ld_data = '0; ld_last = 0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, '0, 0);
        step(1, 0, 0, 0, 0, '0, 0);

`ifdef ROM_INIT_EN
        step(0, 1, 0, 0, 0, '0, 0);
        step(0, 1, 7, 0, 0, '0, 0);
        step(0, 0, 0, 1, 0, 16'hBEEF, 1);
        step(0, 1, 0, 0, 0, '0, 0);
        check("rom_replaced", 32'(op), 32'h0000BEEF);
        step(1, 0, 0, 0, 0, '0, 0);
`endif

        // Fetches before any load must be dropped.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, '0, 0);

        // Four-word image, then fetch pc=2.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, i, OP_W'(16'h0101 * (i + 1)), i == 3);
        step(0, 1, 2, 0, 0, '0, 0);
        check("pc2_word", 32'(op), 32'h0303);

        // Out-of-range write during LOAD, then out-of-range fetch.
        step(0, 0, 0, 1, 5, 16'h5555, 0);
        step(0, 0, 0, 1, 45, 16'hDEAD, 0);
        step(0, 0, 0, 1, 6, 16'h6666, 1);
        step(0, 1, 50, 0, 0, '0, 0);
        step(0, 1, 5, 0, 0, '0, 0);

        // Write and fetch together in RUN: write wins.
        step(0, 1, 1, 1, 7, 16'h7777, 0);
        step(0, 1, 1, 1, 8, 16'h8888, 1);
        step(0, 1, 7, 0, 0, '0, 0);

        // Reset mid-load, then a full image overwrites the partial words.
        step(0, 0, 0, 1, 0, 16'hAAAA, 0);
        step(0, 0, 0, 1, 1, 16'hBBBB, 0);
        step(1, 1, 0, 1, 2, 16'hCCCC, 0);
        step(0, 1, 0, 0, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, i, OP_W'($urandom), i == DEPTH - 1);
        for (int i = 0; i < DEPTH + 2; i++) step(0, 1, i, 0, 0, '0, 0);

        // Saturation: rewrite more than DEPTH words in one load.
        for (int i = 0; i < DEPTH + 5; i++) step(0, 0, 0, 1, i % DEPTH, OP_W'($urandom), 0);
        step(0, 0, 0, 1, 3, 16'h1234, 1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bit r = ($urandom_range(0, 59) == 0);
            bit f = ($urandom_range(0, 9) < 7);
            bit v = ($urandom_range(0, 9) < 3);
            bit l = ($urandom_range(0, 4) == 0);
            step(r, f, $urandom_range(0, 47), v, $urandom_range(0, 50), OP_W'($urandom), l);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
